// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over the shared ALU and unified memory.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [2:0] imm_src,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3;
    localparam logic [3:0] MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7;
    localparam logic [3:0] ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11;
    localparam logic [3:0] JALRLINK = 4'd12, LUI = 4'd13, AUIPC = 4'd14, TRAP = 4'd15;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

    logic [3:0] next_state;
    logic       pc_write_d, mem_write_d, ir_write_d, reg_write_d, retire_d;

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] res;
        case (f3)
            3'b000:  res = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  res = ALU_SLL;
            3'b010:  res = ALU_SLT;
            3'b011:  res = ALU_SLTU;
            3'b100:  res = ALU_XOR;
            3'b101:  res = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  res = ALU_OR;
            default: res = ALU_AND;
        endcase
        return res;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        logic res;
        case (f3)
            3'b000:  res = z;
            3'b001:  res = !z;
            3'b100:  res = l;
            3'b101:  res = !l;
            3'b110:  res = lu;
            3'b111:  res = !lu;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RESET_STATE;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == TRAP)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: next_state = MEMADR;
                    7'b0110011:             next_state = EXECR;
                    7'b0010011:             next_state = EXECI;
                    7'b1100011:             next_state = BRANCH;
                    7'b1101111:             next_state = JAL;
                    7'b1100111:             next_state = JALR;
                    7'b0110111:             next_state = LUI;
                    7'b0010111:             next_state = AUIPC;
                    default:                next_state = TRAP;
                endcase
            end
            MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) next_state = MEMWB;
            MEMWRITE: if (mem_ready) next_state = FETCH;
            EXECR, EXECI, JAL, JALRLINK, LUI, AUIPC: next_state = ALUWB;
            JALR:     next_state = JALRLINK;
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        pc_write_d  = 1'b0;
        mem_write_d = 1'b0;
        ir_write_d  = 1'b0;
        reg_write_d = 1'b0;
        retire_d    = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = IMM_I;
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_d = mem_ready;
                pc_write_d = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (op == 7'b1100011)
                    imm_src = IMM_B;
                else if (op == 7'b1101111)
                    imm_src = IMM_J;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = op[5] ? IMM_S : IMM_I;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src  = 2'b01;
                reg_write_d = 1'b1;
                retire_d    = 1'b1;
            end
            MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_d = 1'b1;
                retire_d    = mem_ready;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_decode(funct3, funct7b5, 1'b1);
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_decode(funct3, funct7b5, 1'b0);
            end
            ALUWB: begin
                reg_write_d = 1'b1;
                retire_d    = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                retire_d    = 1'b1;
                pc_write_d  = branch_taken(funct3, zero, lt, ltu);
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_d = 1'b1;
            end
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write_d = 1'b1;
            end
            JALRLINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
            end
            AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
            end
            default: ;
        endcase
    end

    // Enables are forced low for as long as reset is held, even in FETCH.
    assign pc_write  = pc_write_d  & rst_n;
    assign mem_write = mem_write_d & rst_n;
    assign ir_write  = ir_write_d  & rst_n;
    assign reg_write = reg_write_d & rst_n;
    assign retire    = retire_d    & rst_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random instruction stream checked per retired
// instruction against a latency/effect model, plus reset, trap and abort cases.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, lt, ltu, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [3:0] alu_control, state;
    logic [2:0] imm_src;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_src(imm_src), .retire(retire), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cycles;
        int         rw;
        int         mw;
        int         pw;
        int         iw;
        logic [1:0] rs;
        int         chk_idx;
        logic [3:0] chk_state;
        logic [3:0] chk_alu;
    } exp_t;

    localparam int NI = 200;

    exp_t sb[$];
    exp_t e_mon;
    int   checks = 0;
    int   failures = 0;
    int   retires = 0;
    bit   mon_en = 1'b0;

    int         m_cyc, m_rw, m_mw, m_pw, m_iw;
    logic [1:0] m_rs;
    logic [3:0] st_log [0:63];
    logic [3:0] alu_log[0:63];

    logic [6:0] op_tbl[0:8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [3:0] alu_by_f3[0:7] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic clear_mon();
        m_cyc = 0; m_rw = 0; m_mw = 0; m_pw = 0; m_iw = 0; m_rs = 2'b00;
    endtask

    // Monitor: accumulates what the DUT did since the last retire and scores it.
    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                m_cyc++;
                if (m_cyc < 64) begin
                    st_log[m_cyc]  = state;
                    alu_log[m_cyc] = alu_control;
                end
                if (reg_write) begin m_rw++; m_rs = result_src; end
                if (mem_write) m_mw++;
                if (pc_write)  m_pw++;
                if (ir_write)  m_iw++;
                if (retire) begin
                    retires++;
                    if (sb.size() == 0) begin
                        check("unexpected_retire", 1, 0);
                    end else begin
                        e_mon = sb.pop_front();
                        check("latency", m_cyc, e_mon.cycles);
                        check("reg_write_cnt", m_rw, e_mon.rw);
                        check("mem_write_cnt", m_mw, e_mon.mw);
                        check("pc_write_cnt", m_pw, e_mon.pw);
                        check("ir_write_cnt", m_iw, e_mon.iw);
                        if (e_mon.rw > 0) check("result_src_wb", m_rs, e_mon.rs);
                        check("exec_state", st_log[e_mon.chk_idx], e_mon.chk_state);
                        check("exec_alu", alu_log[e_mon.chk_idx], e_mon.chk_alu);
                        check("illegal_clear", illegal, 0);
                    end
                    clear_mon();
                end else if (m_cyc >= 60) begin
                    check("retire_timeout", m_cyc, 0);
                    clear_mon();
                end
            end
        end
    end

    function automatic logic taken_ref(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        if (f3 == 3'b010 || f3 == 3'b011) return 1'b0;
        if (f3[2:1] == 2'b00) return f3[0] ? !z : z;
        if (f3[2:1] == 2'b10) return f3[0] ? !l : l;
        return f3[0] ? !lu : lu;
    endfunction

    initial begin
        exp_t e;
        int   k, fs, ms;
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;

        #12;
        check("rst_state", state, 0);
        check("rst_illegal", illegal, 0);
        check("rst_enables", {pc_write, ir_write, reg_write, mem_write, retire}, 0);

        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int n = 0; n < NI; n++) begin
            k = $urandom_range(0, 8);
            op = op_tbl[k];
            funct3 = 3'($urandom); funct7b5 = 1'($urandom);
            zero = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
            fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            ms = (k < 2) ? $urandom_range(0, 3) : 0;

            e.iw = 1; e.pw = 1; e.mw = 0; e.rw = 1; e.rs = 2'b00;
            e.chk_idx = fs + 3; e.chk_alu = 4'd0;
            case (k)
                0: begin e.cycles = fs + 5 + ms; e.rs = 2'b01; e.chk_state = 4'd2; end
                1: begin e.cycles = fs + 4 + ms; e.rw = 0; e.mw = ms + 1; e.chk_state = 4'd2; end
                2, 3: begin
                    e.cycles = fs + 4;
                    e.chk_state = (k == 2) ? 4'd6 : 4'd7;
                    e.chk_alu = alu_by_f3[funct3];
                    if (funct3 == 3'b101 && funct7b5) e.chk_alu = 4'd9;
                    if (funct3 == 3'b000 && funct7b5 && k == 2) e.chk_alu = 4'd1;
                end
                4: begin
                    e.cycles = fs + 3; e.rw = 0; e.chk_state = 4'd9; e.chk_alu = 4'd1;
                    e.pw = 1 + int'(taken_ref(funct3, zero, lt, ltu));
                end
                5: begin e.cycles = fs + 4; e.pw = 2; e.chk_state = 4'd10; end
                6: begin e.cycles = fs + 5; e.pw = 2; e.chk_state = 4'd11; end
                7: begin e.cycles = fs + 4; e.chk_state = 4'd13; end
                default: begin e.cycles = fs + 4; e.chk_state = 4'd14; end
            endcase
            sb.push_back(e);

            for (int c = 0; c < e.cycles; c++) begin
                if (c < fs) mem_ready = 1'b0;
                else if (c == fs) mem_ready = 1'b1;
                else if (k < 2 && c >= fs + 3 && c < fs + 3 + ms) mem_ready = 1'b0;
                else if (k < 2 && c == fs + 3 + ms) mem_ready = 1'b1;
                else mem_ready = 1'($urandom);
                @(posedge clk); #1;
            end
        end

        mon_en = 1'b0;
        check("scoreboard_drained", sb.size(), 0);
        check("retire_count", retires, NI);

        // Illegal opcode: FETCH, DECODE, then parked in TRAP.
        op = 7'b0000000; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            check("trap_state", state, 15);
            check("trap_illegal", illegal, 1);
            check("trap_enables", {pc_write, ir_write, reg_write, mem_write, retire}, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("trap_rst_state", state, 0);
        check("trap_rst_illegal", illegal, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Store aborted by reset while waiting in MEMWRITE.
        op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("sw_wait_state", state, 5);
        check("sw_wait_mem_write", mem_write, 1);
        check("sw_wait_retire", retire, 0);
        #2;
        rst_n = 1'b0;
        #1;
        mem_ready = 1'b1;
        #1;
        check("abort_state", state, 0);
        check("abort_mem_write", mem_write, 0);
        check("abort_retire", retire, 0);
        check("abort_enables", {pc_write, ir_write, reg_write}, 0);
        @(posedge clk); #1;
        check("abort_hold_state", state, 0);
        check("abort_hold_enables", {pc_write, ir_write, reg_write, mem_write, retire}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_fetch", state, 0);
        check("after_rst_ir_write", ir_write, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. It takes the opcode and function fields split out by the instruction decoder, together with the ALU flags and a memory ready handshake. From these it sequences the shared ALU, unified memory, instruction register and register file through fetch, decode, execute, memory and writeback. It also reports instruction retirement and illegal opcodes.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); only FETCH is supported.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  load PC
adr_src  out  1  0: address = PC, 1: address = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  load IR and OldPC
reg_write  out  1  register file write
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 reg A, 11 zero
alu_src_b  out  2  00 reg B, 01 ImmExt, 10 constant 4
alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
retire  out  1  one-cycle pulse on the final cycle of each instruction
illegal  out  1  sticky; set in TRAP
state  out  4  current state, for debug

Behaviour:
- Clock and reset: single clock; rst_n is asynchronous and active-low. Reset forces state to FETCH and clears illegal.
- Outputs are a Moore decode of state. The exceptions are pc_write, ir_write and retire, which also depend on mem_ready and flags as listed below.
- While rst_n = 0, all enables (pc_write, ir_write, reg_write, mem_write, retire) are 0.
- Outputs not listed for a state are 0 or 00.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6
  - EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, JALRLINK=12, LUI=13, AUIPC=14, TRAP=15
- FETCH:
  - adr_src=0, a=PC, b=4, result_src=10.
  - ir_write and pc_write are asserted only when mem_ready=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE:
  - a=OldPC, b=ImmExt, add, imm_src=B for branch, J for jal, else I (precomputes the target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - any other op → TRAP
- MEMADR: a=rs1, b=ImmExt, add, imm_src=S if op[5] else I. Goes to MEMWRITE if op[5]=1, else MEMREAD.
- MEMREAD: adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write, retire. Goes to FETCH.
- MEMWRITE: adr_src=1, mem_write held high until mem_ready. On the mem_ready cycle: retire, then FETCH.
- EXECR / EXECI:
  - a=rs1, b=reg B (EXECR) or ImmExt (EXECI, imm_src=I). Then ALUWB.
  - ALU op from funct3:
    - 000: add, or sub when EXECR and funct7b5=1
    - 001: sll
    - 010: slt
    - 011: sltu
    - 100: xor
    - 101: sra if funct7b5 else srl (both R and I)
    - 110: or
    - 111: and
- ALUWB: result_src=00, reg_write, retire. Goes to FETCH.
- BRANCH:
  - a=rs1, b=reg B, sub, result_src=00, retire.
  - Taken condition by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu. funct3 010 or 011 is never taken.
  - pc_write = taken, in this cycle only. Goes to FETCH.
- JAL: a=OldPC, b=4, add, result_src=00, pc_write. Goes to ALUWB.
- JALR: a=rs1, b=ImmExt, imm_src=I, add, result_src=10, pc_write. Goes to JALRLINK.
- JALRLINK: a=OldPC, b=4, add. Goes to ALUWB.
- LUI: a=zero, b=ImmExt, imm_src=U, add. Goes to ALUWB.
- AUIPC: a=OldPC, b=ImmExt, imm_src=U, add. Goes to ALUWB.
- TRAP: illegal=1, all enables 0. Stays in TRAP until reset.
- Latency with mem_ready tied to 1:
  - 4 cycles: R, I, lui, auipc, jal, sw
  - 3 cycles: branch
  - 5 cycles: lw, jalr
  - Each FETCH or MEMREAD/MEMWRITE wait adds one cycle per cycle mem_ready is low.
- Reset mid-instruction: abandons the instruction immediately (asynchronously). No partial reg_write or mem_write occurs after rst_n falls.

Test Plan:
1. add (op=0110011, f3=000, f7b5=0), mem_ready=1 → states 0,1,6,8; alu_control=0000 in EXECR; reg_write and retire high in ALUWB only; 4 cycles.
2. lw (op=0000011) with mem_ready low for 2 cycles in FETCH and for 3 cycles in MEMREAD → FETCH lasts 3 cycles and MEMREAD 4 cycles; result_src=01 and reg_write in MEMWB.
3. beq (f3=000) with zero=1 → pc_write=1 in BRANCH. Repeat with zero=0 → pc_write=0. bltu with ltu=1 → pc_write=1. f3=010 → pc_write=0.
4. jalr (op=1100111) → states 1,11,12,8; pc_write with result_src=10 in JALR; reg_write in ALUWB; 5 cycles total.
5. op=0000000 → TRAP after DECODE; illegal=1 and all enables 0 for 20 cycles; rst_n pulse returns to FETCH with illegal=0.
6. sw with rst_n asserted low during MEMWRITE while mem_ready=0 → mem_write drops in the same cycle; state=FETCH; retire never pulses.
